// File: rtl/dmem_bytelane.sv
// dmem_bytelane: word-organised data memory with byte/halfword/word access.
//
// Loads extract a byte or halfword lane and sign- or zero-extend it. Stores
// update only the addressed lanes. Misaligned, out-of-range and reserved-size
// accesses raise fault; a faulting store writes nothing and a faulting load
// returns zero. After reset, a clear sequencer zeroes every word, one word
// per cycle, while busy is high. Accesses are ignored during the clear.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   we        store request
//   re        load request
//   size      00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   sign_ext  1 = sign-extend byte/halfword loads, 0 = zero-extend
//   a         byte address
//   wd        store data (byte/halfword taken from the low bits)
//   rd        load data, extended to 32 bits
//   busy      high while the clear sequencer runs
//   fault     access error, aligned with rd
//
// Handshake: there is no valid/ready pair. A request is the level of we/re
// in a cycle where busy is low. rd/fault follow after READ_LAT cycles
// (0 = combinational, 1 = registered).
module dmem_bytelane #(
    parameter int DEPTH          = 128,
    parameter int ADDR_W         = 32,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] a,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic              busy,
    output logic              fault
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] cnt;
    logic [31:0]      mem [DEPTH];

    // ---------------- clear sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (cnt == IDX_W'(DEPTH - 1)) state_next = READY;
            READY:   state_next = READY;
            default: state_next = READY;
        endcase
    end

    assign busy = (state == CLEAR);

    // ---------------- address and fault check ----------------
    logic             ready;
    logic             oor;
    logic             misalign;
    logic             fault_c;
    logic [IDX_W-1:0] idx;

    assign ready = (state == READY);
    assign idx   = a[IDX_W+1:2];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_range
            assign oor = |a[ADDR_W-1:IDX_W+2];
        end else begin : g_norange
            assign oor = 1'b0;
        end
    endgenerate

    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b01:   misalign = a[0];
            2'b10:   misalign = |a[1:0];
            2'b11:   misalign = 1'b1;   // reserved size always faults
            default: misalign = 1'b0;
        endcase
    end

    assign fault_c = ready && (we || re) && (oor || misalign);

    // ---------------- load path (array is read before any same-edge store) ----------------
    logic [31:0] word_q;
    logic [7:0]  byte_q;
    logic [15:0] half_q;
    logic [31:0] load_val;
    logic [31:0] rd_c;

    assign word_q = mem[idx];
    assign half_q = a[1] ? word_q[31:16] : word_q[15:0];

    always_comb begin
        byte_q = word_q[7:0];
        case (a[1:0])
            2'd0: byte_q = word_q[7:0];
            2'd1: byte_q = word_q[15:8];
            2'd2: byte_q = word_q[23:16];
            2'd3: byte_q = word_q[31:24];
            default: byte_q = word_q[7:0];
        endcase
    end

    always_comb begin
        load_val = word_q;
        case (size)
            2'b00:   load_val = {{24{sign_ext & byte_q[7]}}, byte_q};
            2'b01:   load_val = {{16{sign_ext & half_q[15]}}, half_q};
            default: load_val = word_q;
        endcase
    end

    assign rd_c = (ready && re && !fault_c) ? load_val : 32'h0;

    // ---------------- store path ----------------
    logic [3:0]  be;
    logic [31:0] wd_lanes;
    logic        store_en;

    assign store_en = ready && we && !fault_c;

    always_comb begin
        be       = 4'b0000;
        wd_lanes = wd;
        case (size)
            2'b00: begin
                be       = 4'b0001 << a[1:0];
                wd_lanes = {4{wd[7:0]}};
            end
            2'b01: begin
                be       = a[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{wd[15:0]}};
            end
            2'b10: begin
                be       = 4'b1111;
                wd_lanes = wd;
            end
            default: begin
                be       = 4'b0000;
                wd_lanes = wd;
            end
        endcase
    end

    // Array has no reset: contents survive reset unless the clear runs.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= 32'h0;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
            end
        end
    end

    // ---------------- output timing ----------------
    generate
        if (READ_LAT == 0) begin : g_lat0
            assign rd    = rd_c;
            assign fault = fault_c;
        end else begin : g_lat1
            logic [31:0] rd_q;
            logic        fault_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q    <= 32'h0;
                    fault_q <= 1'b0;
                end else begin
                    // fault_c is already zero when idle or busy, so it clears itself.
                    fault_q <= fault_c;
                    if (!ready) begin
                        rd_q <= 32'h0;
                    end else if (re) begin
                        rd_q <= rd_c;
                    end
                end
            end

            assign rd    = rd_q;
            assign fault = fault_q;
        end
    endgenerate

endmodule
